sram_controller: RTL and testbench

Responder side of the CPU memory request protocol. It accepts single-word read and write requests from the RAM adapter (`we_i`, `ce_i`, `addr_i`, `data_i`) and answers with a one-cycle `ready_o` pulse. It runs the asynchronous-SRAM pin sequences on the base and ext 1M×32 chips, selecting the chip from an address bit, and sits between the adapter and the board SRAM pins.

---
 rtl/sram_controller_pkg.sv | 40 ++++
 rtl/sram_controller_if.sv | 14 +
 rtl/sram_controller_chip_port.sv | 46 ++++
 rtl/sram_controller.sv | 158 +++++++++++++++
 tb/tb_sram_controller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants, state encoding and payload types for the SRAM controller.
package sram_controller_pkg;

   localparam int unsigned RAM_BUS_W        = 32;
   localparam int unsigned RAM_ADDR_W       = 20;
   localparam int unsigned CPU_ADDR_W       = 32;
   localparam int unsigned RAM_CHIP_SEL_BIT = 22;

   localparam logic CHIP_ENABLE  = 1'b0;
   localparam logic CHIP_DISABLE = 1'b1;
   localparam logic RAM_READ_OP  = 1'b0;
   localparam logic RAM_WRITE_OP = 1'b1;

   typedef enum logic [2:0] {
      SRAM_IDLE     = 3'd0,
      SRAM_RD_WAIT  = 3'd1,
      SRAM_WR_PULSE = 3'd2,
      SRAM_WR_HOLD  = 3'd3,
      SRAM_DONE     = 3'd4
   } sram_state_e;

   // Next-cycle pin levels for one chip; strobes are active-low.
   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic drive;
   } pin_ctrl_t;

   localparam pin_ctrl_t PIN_IDLE = '{ce_n: CHIP_DISABLE, oe_n: CHIP_DISABLE,
                                      we_n: CHIP_DISABLE, drive: 1'b0};

   // Latched request: chip select plus word index, and the write word.
   typedef struct packed {
      logic                          we;
      logic [RAM_CHIP_SEL_BIT:2]     waddr;
      logic [RAM_BUS_W-1:0]          data;
   } sram_req_t;

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side memory request bus between the RAM adapter and the SRAM controller.
interface sram_controller_if;
   import sram_controller_pkg::*;

   logic                  ce_i;
   logic                  we_i;
   logic [CPU_ADDR_W-1:0] addr_i;
   logic [RAM_BUS_W-1:0]  data_i;
   logic                  ready_o;
   logic [RAM_BUS_W-1:0]  data_o;

   modport master (output ce_i, we_i, addr_i, data_i, input ready_o, data_o);
   modport slave  (input ce_i, we_i, addr_i, data_i, output ready_o, data_o);
endinterface

// File: rtl/sram_controller_chip_port.sv
// Pin-side register stage for one asynchronous SRAM chip, including the tri-state data bus.
module sram_chip_port
   import sram_controller_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  pin_ctrl_t             i_ctrl,
   input  logic [RAM_ADDR_W-1:0] i_addr,
   input  logic [RAM_BUS_W-1:0]  i_wdata,
   output logic [RAM_BUS_W-1:0]  o_rdata,
   inout  wire  [RAM_BUS_W-1:0]  io_data,
   output logic [RAM_ADDR_W-1:0] o_addr,
   output logic                  o_ce_n,
   output logic                  o_oe_n,
   output logic                  o_we_n
);
   logic                  r_ce_n;
   logic                  r_oe_n;
   logic                  r_we_n;
   logic                  r_drive;
   logic [RAM_ADDR_W-1:0] r_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ce_n  <= CHIP_DISABLE;
         r_oe_n  <= CHIP_DISABLE;
         r_we_n  <= CHIP_DISABLE;
         r_drive <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_ce_n  <= i_ctrl.ce_n;
         r_oe_n  <= i_ctrl.oe_n;
         r_we_n  <= i_ctrl.we_n;
         r_drive <= i_ctrl.drive;
         if (i_ctrl.ce_n == CHIP_ENABLE) r_addr <= i_addr;
      end
   end

   // Write data comes from the controller's latched request, so it is stable while driven.
   assign io_data = r_drive ? i_wdata : {RAM_BUS_W{1'bz}};
   assign o_rdata = io_data;
   assign o_addr  = r_addr;
   assign o_ce_n  = r_ce_n;
   assign o_oe_n  = r_oe_n;
   assign o_we_n  = r_we_n;
endmodule

// File: rtl/sram_controller.sv
// Responder for CPU single-word requests; sequences the base/ext asynchronous SRAM pins.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned RD_CYCLES = 2,
   parameter int unsigned WR_CYCLES = 2
)(
   input  logic                  clk,
   input  logic                  rst,
   sram_controller_if.slave      bus,
   inout  wire  [RAM_BUS_W-1:0]  base_ram_data,
   output logic [RAM_ADDR_W-1:0] base_ram_addr,
   output logic                  base_ram_ce,
   output logic                  base_ram_oe,
   output logic                  base_ram_we,
   inout  wire  [RAM_BUS_W-1:0]  ext_ram_data,
   output logic [RAM_ADDR_W-1:0] ext_ram_addr,
   output logic                  ext_ram_ce,
   output logic                  ext_ram_oe,
   output logic                  ext_ram_we
);
   localparam int unsigned CYC_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);

   sram_state_e          r_state, w_state_next;
   logic [CNT_W-1:0]     r_cnt, w_cnt_next;
   sram_req_t            r_req, w_req_next;
   logic                 r_abort, w_abort_next;
   logic                 r_ready, w_ready_next;
   logic [RAM_BUS_W-1:0] r_data, w_data_next;
   logic                 w_abort_now;
   pin_ctrl_t            w_ctrl, w_base_ctrl, w_ext_ctrl;
   logic [RAM_BUS_W-1:0] w_base_rdata, w_ext_rdata, w_rd_sel;
   logic                 w_unused_addr;

   assign w_unused_addr = ^{bus.addr_i[CPU_ADDR_W-1:RAM_CHIP_SEL_BIT+1], bus.addr_i[1:0]};
   assign w_rd_sel = r_req.waddr[RAM_CHIP_SEL_BIT] ? w_ext_rdata : w_base_rdata;
   assign w_abort_now = !bus.ce_i || (bus.we_i != r_req.we)
                        || (bus.addr_i[RAM_CHIP_SEL_BIT:2] != r_req.waddr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SRAM_IDLE;
         r_cnt   <= '0;
         r_req   <= '0;
         r_abort <= 1'b0;
         r_ready <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_req   <= w_req_next;
         r_abort <= w_abort_next;
         r_ready <= w_ready_next;
         r_data  <= w_data_next;
      end
   end

   // Pin levels are computed for the next cycle and registered in the chip ports.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_req_next   = r_req;
      w_abort_next = r_abort;
      w_ready_next = 1'b0;
      w_data_next  = r_data;
      w_ctrl       = PIN_IDLE;
      unique case (r_state)
         SRAM_IDLE: begin
            if (bus.ce_i) begin
               w_req_next   = '{we: bus.we_i, waddr: bus.addr_i[RAM_CHIP_SEL_BIT:2],
                                data: bus.data_i};
               w_cnt_next   = '0;
               w_abort_next = 1'b0;
               w_state_next = (bus.we_i == RAM_WRITE_OP) ? SRAM_WR_PULSE : SRAM_RD_WAIT;
            end
         end
         SRAM_RD_WAIT: begin
            w_abort_next = r_abort || w_abort_now;
            if (r_cnt == CNT_W'(RD_CYCLES)) begin
               w_abort_next = 1'b0;
               if (r_abort || w_abort_now) begin
                  w_state_next = SRAM_IDLE;
               end else begin
                  w_ready_next = 1'b1;
                  w_data_next  = w_rd_sel;
                  w_state_next = SRAM_DONE;
               end
            end else begin
               w_ctrl     = '{ce_n: CHIP_ENABLE, oe_n: CHIP_ENABLE, we_n: CHIP_DISABLE, drive: 1'b0};
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         SRAM_WR_PULSE: begin
            w_abort_next = r_abort || w_abort_now;
            if (r_cnt == CNT_W'(WR_CYCLES)) begin
               w_ctrl       = '{ce_n: CHIP_ENABLE, oe_n: CHIP_DISABLE, we_n: CHIP_DISABLE, drive: 1'b1};
               w_state_next = SRAM_WR_HOLD;
            end else begin
               w_ctrl     = '{ce_n: CHIP_ENABLE, oe_n: CHIP_DISABLE, we_n: CHIP_ENABLE, drive: 1'b1};
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         SRAM_WR_HOLD: begin
            w_abort_next = 1'b0;
            if (r_abort) begin
               w_state_next = SRAM_IDLE;
            end else begin
               w_ready_next = 1'b1;
               w_state_next = SRAM_DONE;
            end
         end
         SRAM_DONE: begin
            if (!bus.ce_i) w_state_next = SRAM_IDLE;
         end
         default: w_state_next = SRAM_IDLE;
      endcase
   end

   // The unselected chip always sees idle pin levels.
   always_comb begin
      w_base_ctrl = PIN_IDLE;
      w_ext_ctrl  = PIN_IDLE;
      if (r_req.waddr[RAM_CHIP_SEL_BIT]) w_ext_ctrl = w_ctrl;
      else                               w_base_ctrl = w_ctrl;
   end

   sram_chip_port u_base (
      .clk     (clk),
      .rst     (rst),
      .i_ctrl  (w_base_ctrl),
      .i_addr  (r_req.waddr[RAM_CHIP_SEL_BIT-1:2]),
      .i_wdata (r_req.data),
      .o_rdata (w_base_rdata),
      .io_data (base_ram_data),
      .o_addr  (base_ram_addr),
      .o_ce_n  (base_ram_ce),
      .o_oe_n  (base_ram_oe),
      .o_we_n  (base_ram_we)
   );

   sram_chip_port u_ext (
      .clk     (clk),
      .rst     (rst),
      .i_ctrl  (w_ext_ctrl),
      .i_addr  (r_req.waddr[RAM_CHIP_SEL_BIT-1:2]),
      .i_wdata (r_req.data),
      .o_rdata (w_ext_rdata),
      .io_data (ext_ram_data),
      .o_addr  (ext_ram_addr),
      .o_ce_n  (ext_ram_ce),
      .o_oe_n  (ext_ram_oe),
      .o_we_n  (ext_ram_we)
   );

   assign bus.ready_o = r_ready;
   assign bus.data_o  = r_data;
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: SRAM pin models plus a ready_o/data_o scoreboard.
module tb_sram_controller;
   logic        clk;
   logic        rst;
   wire  [31:0] base_ram_data;
   wire  [31:0] ext_ram_data;
   logic [19:0] base_ram_addr, ext_ram_addr;
   logic        base_ram_ce, base_ram_oe, base_ram_we;
   logic        ext_ram_ce, ext_ram_oe, ext_ram_we;

   logic [31:0] base_mem [0:255];
   logic [31:0] ext_mem  [0:255];
   logic [31:0] exp_q [$];
   int          checks = 0;
   int          failures = 0;
   int          ready_cnt = 0;
   int          base_acc = 0;
   int          acc0, r0;

   sram_controller_if bus ();

   sram_controller #(.RD_CYCLES(2), .WR_CYCLES(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .base_ram_data (base_ram_data),
      .base_ram_addr (base_ram_addr),
      .base_ram_ce   (base_ram_ce),
      .base_ram_oe   (base_ram_oe),
      .base_ram_we   (base_ram_we),
      .ext_ram_data  (ext_ram_data),
      .ext_ram_addr  (ext_ram_addr),
      .ext_ram_ce    (ext_ram_ce),
      .ext_ram_oe    (ext_ram_oe),
      .ext_ram_we    (ext_ram_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous SRAM models: read while ce/oe low, write on the rising edge of we.
   assign base_ram_data = (!base_ram_ce && !base_ram_oe) ? base_mem[base_ram_addr[7:0]] : 32'bz;
   assign ext_ram_data  = (!ext_ram_ce && !ext_ram_oe) ? ext_mem[ext_ram_addr[7:0]] : 32'bz;
   always @(posedge base_ram_we) if (!base_ram_ce) base_mem[base_ram_addr[7:0]] <= base_ram_data;
   always @(posedge ext_ram_we)  if (!ext_ram_ce)  ext_mem[ext_ram_addr[7:0]]   <= ext_ram_data;
   always @(negedge base_ram_ce) base_acc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every ready_o pulse consumes one expected data_o value.
   always @(negedge clk) begin
      if (bus.ready_o) begin
         ready_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready: data_o %h with no request pending", bus.data_o);
         end else begin
            check("sb_data_o", bus.data_o, exp_q.pop_front());
         end
      end
   end

   task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int exp_lat, input int hold, input string name);
      int lat;
      lat = 20;
      bus.ce_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.data_i = data;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (bus.ready_o) begin
            lat = n;
            break;
         end
      end
      check(name, 32'(lat), 32'(exp_lat));
      repeat (hold) tick();
      bus.ce_i = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         base_mem[i] = 32'h0;
         ext_mem[i]  = 32'h0;
      end
      base_mem[16] = 32'hDEADBEEF;
      base_mem[32] = 32'hCAFEF00D;
      base_mem[48] = 32'h0BADC0DE;
      rst = 1'b1;
      bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'h0; bus.data_i = 32'h0;
      repeat (3) tick();
      check("rst_ready", 32'(bus.ready_o), 32'd0);
      check("rst_data_o", bus.data_o, 32'h0);
      check("rst_base_strb", 32'({base_ram_ce, base_ram_oe, base_ram_we}), 32'h7);
      check("rst_ext_strb", 32'({ext_ram_ce, ext_ram_oe, ext_ram_we}), 32'h7);
      check("rst_base_addr", 32'(base_ram_addr), 32'h0);
      check("rst_ext_addr", 32'(ext_ram_addr), 32'h0);
      rst = 1'b0;
      tick();

      // Read base word 0x10 with cycle-by-cycle pin checks
      exp_q.push_back(32'hDEADBEEF);
      bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_0040;
      tick();
      check("rd_e0_oe", 32'(base_ram_oe), 32'd1);
      tick();
      check("rd_e1_ce_oe", 32'({base_ram_ce, base_ram_oe}), 32'd0);
      check("rd_e1_addr", 32'(base_ram_addr), 32'h10);
      check("rd_e1_ext_ce", 32'(ext_ram_ce), 32'd1);
      check("rd_e1_ready", 32'(bus.ready_o), 32'd0);
      tick();
      check("rd_e2_oe", 32'(base_ram_oe), 32'd0);
      check("rd_e2_ready", 32'(bus.ready_o), 32'd0);
      tick();
      check("rd_e3_ready", 32'(bus.ready_o), 32'd1);
      check("rd_e3_oe", 32'(base_ram_oe), 32'd1);
      bus.ce_i = 1'b0;
      tick();
      check("rd_e4_ready", 32'(bus.ready_o), 32'd0);

      // Write ext word 2; data_o must keep the last read value
      exp_q.push_back(32'hDEADBEEF);
      bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0040_0008; bus.data_i = 32'h1234_5678;
      tick();
      check("wr_e0_we", 32'(ext_ram_we), 32'd1);
      tick();
      check("wr_e1_strb", 32'({ext_ram_ce, ext_ram_oe, ext_ram_we}), 32'b010);
      check("wr_e1_addr", 32'(ext_ram_addr), 32'h2);
      check("wr_e1_bus", ext_ram_data, 32'h1234_5678);
      check("wr_e1_base_ce", 32'(base_ram_ce), 32'd1);
      tick();
      check("wr_e2_we", 32'(ext_ram_we), 32'd0);
      tick();
      check("wr_e3_strb", 32'({ext_ram_ce, ext_ram_oe, ext_ram_we}), 32'b011);
      check("wr_e3_bus", ext_ram_data, 32'h1234_5678);
      check("wr_e3_ready", 32'(bus.ready_o), 32'd0);
      tick();
      check("wr_e4_ready", 32'(bus.ready_o), 32'd1);
      check("wr_e4_ce", 32'(ext_ram_ce), 32'd1);
      bus.ce_i = 1'b0;
      tick();
      check("wr_mem", ext_mem[2], 32'h1234_5678);

      exp_q.push_back(32'h1234_5678);
      run_req(1'b0, 32'h0040_0008, 32'h0, 3, 0, "rb_lat");

      // Request held high past ready_o
      exp_q.push_back(32'hDEADBEEF);
      acc0 = base_acc;
      r0 = ready_cnt;
      run_req(1'b0, 32'h0000_0040, 32'h0, 3, 5, "held_lat");
      check("held_acc", 32'(base_acc - acc0), 32'd1);
      check("held_ready", 32'(ready_cnt - r0), 32'd1);

      // Address change mid-read aborts; pins finish, no ready, data_o kept
      r0 = ready_cnt;
      bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_0080;
      tick();
      tick();
      bus.addr_i = 32'h0000_00C0;
      tick();
      check("ab_e2_oe", 32'(base_ram_oe), 32'd0);
      tick();
      check("ab_e3_ready", 32'(bus.ready_o), 32'd0);
      check("ab_e3_oe", 32'(base_ram_oe), 32'd1);
      check("ab_data_o", bus.data_o, 32'hDEADBEEF);
      bus.ce_i = 1'b0;
      tick();
      check("ab_ready_cnt", 32'(ready_cnt - r0), 32'd0);
      exp_q.push_back(32'h0BAD_C0DE);
      run_req(1'b0, 32'h0000_00C0, 32'h0, 3, 0, "ab_next_lat");

      // ce_i dropped during a write pulse
      r0 = ready_cnt;
      bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0000_0100; bus.data_i = 32'h55AA_55AA;
      tick();
      bus.ce_i = 1'b0;
      tick();
      check("wab_e1_we", 32'(base_ram_we), 32'd0);
      repeat (3) tick();
      check("wab_e4_ready", 32'(bus.ready_o), 32'd0);
      check("wab_e4_ce", 32'(base_ram_ce), 32'd1);
      tick();
      check("wab_ready_cnt", 32'(ready_cnt - r0), 32'd0);

      // Reset during WR_PULSE
      bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0040_000C; bus.data_i = 32'hA5A5_A5A5;
      tick();
      tick();
      check("rstw_pre_we", 32'(ext_ram_we), 32'd0);
      rst = 1'b1;
      tick();
      check("rstw_ext_strb", 32'({ext_ram_ce, ext_ram_oe, ext_ram_we}), 32'h7);
      check("rstw_base_strb", 32'({base_ram_ce, base_ram_oe, base_ram_we}), 32'h7);
      check("rstw_ready", 32'(bus.ready_o), 32'd0);
      check("rstw_data_o", bus.data_o, 32'h0);
      check("rstw_ext_addr", 32'(ext_ram_addr), 32'h0);
      bus.ce_i = 1'b0;
      rst = 1'b0;
      repeat (3) tick();
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
